// File: rtl/srff_flag_arbiter_if.sv
// Request/grant bundle for srff_flag_arbiter: per-channel set/clear levels,
// the service-done strobe, and the registered flag/grant status.
interface srff_flag_arbiter_if #(
  parameter int unsigned N = 4
) ();
  localparam int unsigned IdW = $clog2(N);

  logic [N-1:0]   set_in;
  logic [N-1:0]   clr_in;
  logic           done;
  logic [N-1:0]   pending;
  logic [N-1:0]   grant;
  logic [IdW-1:0] grant_id;
  logic           busy;
  logic           timeout;

  modport master (
    output set_in, clr_in, done,
    input  pending, grant, grant_id, busy, timeout
  );

  modport slave (
    input  set_in, clr_in, done,
    output pending, grant, grant_id, busy, timeout
  );
endinterface

// File: rtl/srff_flag_arbiter.sv
// Sticky SR request flags served by a round-robin arbiter with one grant at a
// time, a one-cycle release gap, and a forced release after TIMEOUT cycles.
module srff_flag_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                clk,
  input logic                reset,
  srff_flag_arbiter_if.slave bus
);
  localparam int unsigned IdW     = $clog2(N);
  localparam logic [7:0]  CntLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [IdW-1:0] last_id_q, last_id_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           timeout_q, timeout_d;

  logic           in_grant;
  logic           cancel;
  logic           expire;
  logic           sel_found;
  logic [IdW-1:0] sel_id;

  // While granted, last_id_q always holds the granted channel.
  assign in_grant = (state_q == StGrant);
  assign cancel   = bus.clr_in[last_id_q];
  assign expire   = (cnt_q >= CntLast);

  // Rotating-priority search starting just above the last winner.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int k = 1; k <= int'(N); k++) begin
      idx = (int'(last_id_q) + k) % int'(N);
      if (!sel_found && pending_q[idx]) begin
        sel_found = 1'b1;
        sel_id    = IdW'(idx);
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < int'(N); i++) begin
      if (bus.clr_in[i]) begin
        pending_d[i] = 1'b0;
      end else if (bus.set_in[i]) begin
        pending_d[i] = 1'b1;
      end else if (in_grant && bus.done && (int'(last_id_q) == i)) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    cnt_d     = 8'd0;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d   = StGrant;
          last_id_d = sel_id;
        end
      end
      StGrant: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        // done takes precedence over cancel and expiry, so no pulse with it.
        if (bus.done || cancel) begin
          state_d = StRelease;
        end else if (expire) begin
          state_d   = StRelease;
          timeout_d = 1'b1;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      last_id_q <= IdW'(N - 1);
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      last_id_q <= last_id_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    bus.pending  = pending_q;
    bus.busy     = in_grant;
    bus.timeout  = timeout_q;
    bus.grant    = '0;
    bus.grant_id = '0;
    if (in_grant) begin
      bus.grant[last_id_q] = 1'b1;
      bus.grant_id         = last_id_q;
    end
  end
endmodule
